// File: rtl/cci_mpf_if_pkg.sv
// Shared types and parameter checks for the CCI MPF transmit buffer.
// Included first; imported by the channel FIFO and the top.
package cci_mpf_if_pkg;

  localparam int MAX_DEPTH = 1024;
  localparam int OCC_W     = $clog2(MAX_DEPTH + 1);

  typedef logic [OCC_W-1:0] occ_t;

  function automatic int occ_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic logic params_ok(
    input int n,
    input int w,
    input int d,
    input int s
  );
    return (n >= 1) && (n <= 8) &&
           (w >= 1) &&
           (d >= 4) && (d <= MAX_DEPTH) &&
           ((d & (d - 1)) == 0) &&
           (s >= 1) && (s <= d - 1);
  endfunction

endpackage

// File: rtl/cci_mpf_shim_tx_buffer_chan.sv
// Single-channel request FIFO with registered output,
// almost-full and sticky overflow flags.
module cci_mpf_shim_tx_buffer_chan
  import cci_mpf_if_pkg::*;
#(
  parameter int DATA_WIDTH     = 640,
  parameter int DEPTH          = 16,
  parameter int ALM_FULL_SLACK = 4,
  parameter int OW             = 5
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_valid,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_fiu_alm_full,
  output logic                  o_alm_full,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [OW-1:0]         o_occ,
  output logic                  o_ovf
);

  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_data;
  logic [PW-1:0]         r_head;
  logic [PW-1:0]         r_tail;
  occ_t                  r_occ;
  logic                  r_valid;
  logic                  r_alm;
  logic                  r_ovf;

  occ_t w_occ_nxt;
  logic w_full;
  logic w_empty;
  logic w_pop;
  logic w_push;

  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_full  = (r_occ == occ_t'(DEPTH));
  assign w_empty = (r_occ == '0);
  assign w_pop   = !w_empty && !i_fiu_alm_full;
  assign w_push  = i_valid && (!w_full || w_pop);

  always_comb begin
    w_occ_nxt = r_occ;
    unique case (1'b1)
      w_push && !w_pop: w_occ_nxt = r_occ + 1'b1;
      !w_push && w_pop: w_occ_nxt = r_occ - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_occ   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_valid <= 1'b0;
      r_ovf   <= 1'b0;
      r_alm   <= 1'b1;
    end else begin
      r_occ   <= w_occ_nxt;
      r_valid <= w_pop;
      r_alm   <= (w_occ_nxt >= occ_t'(DEPTH - ALM_FULL_SLACK));
      if (w_pop)
        r_head <= r_head + 1'b1;
      if (w_push)
        r_tail <= r_tail + 1'b1;
      if (i_valid && !w_push)
        r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push)
      r_mem[r_tail] <= i_data;
    if (w_pop)
      r_data <= r_mem[r_head];
  end

  assign o_alm_full = r_alm;
  assign o_valid    = r_valid;
  assign o_data     = r_data;
  assign o_occ      = r_occ[OW-1:0];
  assign o_ovf      = r_ovf;

endmodule

// File: rtl/cci_mpf_shim_tx_buffer.sv
// Multi-channel AFU->FIU transmit buffer: one independent
// FIFO per request channel.
module cci_mpf_shim_tx_buffer
  import cci_mpf_if_pkg::*;
#(
  parameter int NUM_CHANNELS   = 2,
  parameter int DATA_WIDTH     = 640,
  parameter int DEPTH          = 16,
  parameter int ALM_FULL_SLACK = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic [NUM_CHANNELS-1:0]            afu_tx_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0] afu_tx_data,
  output logic [NUM_CHANNELS-1:0]            afu_alm_full,
  output logic [NUM_CHANNELS-1:0]            fiu_tx_valid,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] fiu_tx_data,
  input  logic [NUM_CHANNELS-1:0]            fiu_alm_full,
  output logic [NUM_CHANNELS*occ_w(DEPTH)-1:0] occupancy,
  output logic [NUM_CHANNELS-1:0]            overflow_err
);

  localparam int OW = occ_w(DEPTH);

  if (!params_ok(NUM_CHANNELS, DATA_WIDTH, DEPTH, ALM_FULL_SLACK)) begin : g_bad
    $error("cci_mpf_shim_tx_buffer: illegal parameters");
  end

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
    cci_mpf_shim_tx_buffer_chan #(
      .DATA_WIDTH     (DATA_WIDTH),
      .DEPTH          (DEPTH),
      .ALM_FULL_SLACK (ALM_FULL_SLACK),
      .OW             (OW)
    ) u_chan (
      .clk            (clk),
      .reset_n        (reset_n),
      .i_valid        (afu_tx_valid[g]),
      .i_data         (afu_tx_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .i_fiu_alm_full (fiu_alm_full[g]),
      .o_alm_full     (afu_alm_full[g]),
      .o_valid        (fiu_tx_valid[g]),
      .o_data         (fiu_tx_data[g*DATA_WIDTH +: DATA_WIDTH]),
      .o_occ          (occupancy[g*OW +: OW]),
      .o_ovf          (overflow_err[g])
    );
  end

endmodule

// File: tb/tb_cci_mpf_shim_tx_buffer.sv
// Scoreboard bench for cci_mpf_shim_tx_buffer: directed
// stimulus pushes expected payloads, a monitor checks outputs.
module tb_cci_mpf_shim_tx_buffer;

  localparam int N  = 2;
  localparam int W  = 640;
  localparam int D  = 16;
  localparam int OW = 5;

  logic             clk;
  logic             reset_n;
  logic [N-1:0]     afu_tx_valid;
  logic [N*W-1:0]   afu_tx_data;
  logic [N-1:0]     afu_alm_full;
  logic [N-1:0]     fiu_tx_valid;
  logic [N*W-1:0]   fiu_tx_data;
  logic [N-1:0]     fiu_alm_full;
  logic [N*OW-1:0]  occupancy;
  logic [N-1:0]     overflow_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] q0[$];
  logic [W-1:0] q1[$];

  cci_mpf_shim_tx_buffer #(
    .NUM_CHANNELS   (N),
    .DATA_WIDTH     (W),
    .DEPTH          (D),
    .ALM_FULL_SLACK (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .afu_tx_valid (afu_tx_valid),
    .afu_tx_data  (afu_tx_data),
    .afu_alm_full (afu_alm_full),
    .fiu_tx_valid (fiu_tx_valid),
    .fiu_tx_data  (fiu_tx_data),
    .fiu_alm_full (fiu_alm_full),
    .occupancy    (occupancy),
    .overflow_err (overflow_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ext(input logic [31:0] v);
    return {{(W-32){1'b0}}, v};
  endfunction

  function automatic logic [31:0] occ(input int ch);
    return 32'(occupancy[ch*OW +: OW]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drv(input int ch, input logic v, input logic [31:0] val);
    afu_tx_valid[ch] = v;
    afu_tx_data[ch*W +: W] = ext(val);
  endtask

  // Monitor: every presented FIU request must match the queue head.
  initial begin
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (fiu_tx_valid[0]) begin
          checks++;
          if (q0.size() == 0) begin
            errors++;
            $display("FAIL ch0_out unexpected got %0h want none",
                     fiu_tx_data[31:0]);
          end else begin
            e = q0.pop_front();
            if (fiu_tx_data[W-1:0] !== e) begin
              errors++;
              $display("FAIL ch0_out got %0h want %0h",
                       fiu_tx_data[31:0], e[31:0]);
            end
          end
        end
        if (fiu_tx_valid[1]) begin
          checks++;
          if (q1.size() == 0) begin
            errors++;
            $display("FAIL ch1_out unexpected got %0h want none",
                     fiu_tx_data[W+31:W]);
          end else begin
            e = q1.pop_front();
            if (fiu_tx_data[2*W-1:W] !== e) begin
              errors++;
              $display("FAIL ch1_out got %0h want %0h",
                       fiu_tx_data[W+31:W], e[31:0]);
            end
          end
        end
      end
    end
  end

  initial begin
    int k0;
    int k1;
    int n;
    reset_n      = 1'b0;
    afu_tx_valid = '0;
    afu_tx_data  = '0;
    fiu_alm_full = '0;
    repeat (3) tick();
    chk("rst_occ0", occ(0), 0);
    chk("rst_occ1", occ(1), 0);
    chk("rst_fiu_valid", 32'(fiu_tx_valid), 0);
    chk("rst_ovf", 32'(overflow_err), 0);
    chk("rst_alm", 32'(afu_alm_full), 32'h3);
    reset_n = 1'b1;
    tick();
    chk("post_rst_alm", 32'(afu_alm_full), 0);
    repeat (9) tick();

    // single request, two-cycle latency
    drv(0, 1'b1, 32'hA5);
    q0.push_back(ext(32'hA5));
    tick();
    drv(0, 1'b0, 0);
    chk("single_occ", occ(0), 1);
    chk("single_v_t1", 32'(fiu_tx_valid[0]), 0);
    tick();
    chk("single_v_t2", 32'(fiu_tx_valid[0]), 1);
    chk("single_d_t2", fiu_tx_data[31:0], 32'hA5);
    chk("single_ch1_idle", 32'(fiu_tx_valid[1]), 0);
    tick();
    chk("single_v_t3", 32'(fiu_tx_valid[0]), 0);
    chk("single_occ_t3", occ(0), 0);

    // almost-full on ch0
    fiu_alm_full[0] = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drv(0, 1'b1, 32'h100 + k);
      q0.push_back(ext(32'h100 + k));
      tick();
      if (k == 10) begin
        chk("af_occ11", occ(0), 11);
        chk("af_alm_at11", 32'(afu_alm_full[0]), 0);
      end
    end
    drv(0, 1'b0, 0);
    chk("af_occ12", occ(0), 12);
    chk("af_alm_at12", 32'(afu_alm_full[0]), 1);
    chk("af_ovf", 32'(overflow_err), 0);
    fiu_alm_full[0] = 1'b0;
    repeat (20) tick();
    chk("af_drained", occ(0), 0);
    chk("af_q_empty", q0.size(), 0);

    // overflow on ch1
    fiu_alm_full[1] = 1'b1;
    for (int k = 0; k < 17; k++) begin
      drv(1, 1'b1, 32'h200 + k);
      if (k < 16) q1.push_back(ext(32'h200 + k));
      tick();
    end
    drv(1, 1'b0, 0);
    chk("ovf_occ16", occ(1), 16);
    chk("ovf_flag1", 32'(overflow_err[1]), 1);
    chk("ovf_flag0", 32'(overflow_err[0]), 0);
    fiu_alm_full[1] = 1'b0;
    repeat (25) tick();
    chk("ovf_q_empty", q1.size(), 0);
    chk("ovf_drained", occ(1), 0);

    // full with simultaneous pop on ch0
    fiu_alm_full[0] = 1'b1;
    for (int k = 0; k < 16; k++) begin
      drv(0, 1'b1, 32'h300 + k);
      q0.push_back(ext(32'h300 + k));
      tick();
    end
    chk("fp_occ16", occ(0), 16);
    fiu_alm_full[0] = 1'b0;
    drv(0, 1'b1, 32'h3FF);
    q0.push_back(ext(32'h3FF));
    tick();
    drv(0, 1'b0, 0);
    chk("fp_occ_stay", occ(0), 16);
    chk("fp_ovf0", 32'(overflow_err[0]), 0);
    repeat (25) tick();
    chk("fp_q_empty", q0.size(), 0);

    // wrap-around stream with random backpressure
    k0 = 0;
    k1 = 0;
    n  = 0;
    while ((k0 < 100 || k1 < 100) && n < 3000) begin
      fiu_alm_full = 2'($urandom_range(0, 3));
      drv(0, 1'b0, 0);
      drv(1, 1'b0, 0);
      if (k0 < 100 && !afu_alm_full[0] && $urandom_range(0, 3) != 0) begin
        drv(0, 1'b1, 32'h1000 + k0);
        q0.push_back(ext(32'h1000 + k0));
        k0++;
      end
      if (k1 < 100 && !afu_alm_full[1] && $urandom_range(0, 3) != 0) begin
        drv(1, 1'b1, 32'h2000 + k1);
        q1.push_back(ext(32'h2000 + k1));
        k1++;
      end
      tick();
      n++;
    end
    chk("stream_bound", 32'(n < 3000), 1);
    drv(0, 1'b0, 0);
    drv(1, 1'b0, 0);
    fiu_alm_full = '0;
    repeat (30) tick();
    chk("stream_q0", q0.size(), 0);
    chk("stream_q1", q1.size(), 0);
    chk("stream_occ0", occ(0), 0);
    chk("stream_occ1", occ(1), 0);
    chk("stream_ovf0", 32'(overflow_err[0]), 0);

    // mid-operation reset with 7 buffered on ch0
    fiu_alm_full[0] = 1'b1;
    for (int k = 0; k < 7; k++) begin
      drv(0, 1'b1, 32'h400 + k);
      tick();
    end
    drv(0, 1'b0, 0);
    chk("mr_occ7", occ(0), 7);
    reset_n = 1'b0;
    tick();
    chk("mr_occ0", occ(0), 0);
    chk("mr_valid", 32'(fiu_tx_valid), 0);
    chk("mr_alm", 32'(afu_alm_full), 32'h3);
    chk("mr_ovf", 32'(overflow_err), 0);
    reset_n = 1'b1;
    fiu_alm_full = '0;
    tick();
    chk("mr_alm_rel", 32'(afu_alm_full), 0);
    repeat (6) tick();
    chk("mr_still_empty", occ(0), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
